mc_control_unit: RTL
====================

# mc_control_unit

Parametrised multicycle control FSM for the MIPS multicycle datapath, replacing the fixed-latency controller. It decodes opcode/funct and sequences the datapath enables (PC, IR, memory, register file, ALU muxes) one state per cycle. It adds memory wait-state handshaking with a timeout trap, `bne`/`addi`/`jr` support, and an illegal-instruction trap. It also provides a retired-instruction counter. It sits between the IR/ALU outputs and every datapath enable and mux select in the CPU top.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter
- WAIT_EN, 1, 1 = honour `mem_ready`; 0 = memory treated as always ready
- TIMEOUT, 15, max wait cycles in a memory state before trap (range 1..255)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- opcode  in  6  inst[31:26]
- funct  in  6  inst[5:0]
- alu_zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_wr, pc_wr_cond, pc_wr_cond_ne  out  1 each  PC write unconditional / on zero / on not-zero
- iord, mem_rd, mem_wr, mem_to_reg, ir_wr, alu_src_a, reg_wr, reg_dst  out  1 each
- pc_src  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 reg A
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext, 11 sign-ext<<2
- state  out  4  current state code (debug)
- trap  out  1  sticky fault flag
- retired  out  CNT_W  retired-instruction count

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EX, R_WB, I_EX, I_WB, BRANCH, JUMP, JR, TRAP.
- Outputs are Moore (decoded from state), except the memory-state enables, which are qualified by `mem_ready`. Every output not listed for a state is 0.
- FETCH: mem_rd, alu_src_b=01, alu_op=00, pc_src=00. `ir_wr` and `pc_wr` are asserted only when ready; advance to DECODE when ready.
- DECODE: alu_src_b=11, alu_op=00. Next state by opcode:
  - 100011 / 101011 → MEM_ADDR
  - 000000 → R_EX, or JR when funct=001000
  - 001000 → I_EX
  - 000100 / 000101 → BRANCH
  - 000010 → JUMP
  - any other opcode → TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_rd, iord. Advances to MEM_WB when ready.
- MEM_WB: reg_wr, mem_to_reg, reg_dst=0. Goes to FETCH.
- MEM_WR: iord; `mem_wr` is asserted for the whole state. Goes to FETCH when ready.
- R_EX: alu_src_a=1, alu_op=10. R_WB: reg_wr, reg_dst=1.
- I_EX: alu_src_a=1, alu_src_b=10, alu_op=00. I_WB: reg_wr, reg_dst=0.
- BRANCH: alu_src_a=1, alu_op=01, pc_src=01. Asserts pc_wr_cond for beq, pc_wr_cond_ne for bne.
- JUMP: pc_wr, pc_src=10. JR: pc_wr, pc_src=11.
- Ready = `mem_ready` when WAIT_EN=1, else 1.
- Wait counter: cleared on entering any memory state, incremented each not-ready cycle. Reaching TIMEOUT goes to TRAP.
- TRAP: absorbing state; `trap`=1, all enables 0. Only `rst` exits it.
- `retired`: +1 on every transition into FETCH from MEM_WB, MEM_WR, R_WB, I_WB, BRANCH, JUMP, JR. Wraps modulo 2^CNT_W. Does not count TRAP.

## Timing
- Reset: state=FETCH, retired=0, trap=0, wait counter=0. While `rst`=1, all enables are forced to 0 regardless of state.
- Zero-wait latencies, cycles from FETCH entry back to FETCH:
  - lw 5
  - sw, R-type, addi 4
  - beq, bne, j, jr 3
- Each not-ready memory cycle adds 1 cycle. `ir_wr`/`pc_wr` in FETCH pulse for exactly the ready cycle.
- Trap is entered on the edge after the TIMEOUT-th consecutive not-ready cycle.
- Reset asserted mid-instruction (including in TRAP or during a wait): FETCH on the next edge, with no further writes.

## Structure
- Shared package `mc_pkg`:
  - state encoding
  - opcode/funct constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, FN_JR)
  - alu_op, pc_src, alu_src_b codes
- One sub-module, `mc_wait_timer`: wait counter plus timeout compare, with a clear input and a not-ready increment input.

## Test plan
- Reset then lw (opcode 100011), mem_ready=1 → states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB; reg_wr and mem_to_reg high in cycle 5; retired 0→1.
- beq with alu_zero=1, then bne with alu_zero=1 → pc_wr_cond=1 in BRANCH; pc_wr_cond_ne=1 but no PC update in the bne case; both take 3 cycles.
- sw with mem_ready low for 3 cycles, TIMEOUT=15 → mem_wr held 4 cycles in MEM_WR; instruction takes 7 cycles total.
- FETCH with mem_ready held low for 15 cycles → trap=1; state=TRAP; all enables 0; retired unchanged; rst clears it to FETCH.
- Opcode 111111 → TRAP from DECODE. R-type with funct=001000 → JR with pc_src=11 and pc_wr=1.
- CNT_W=4, run 17 R-type instructions → retired wraps to 1. WAIT_EN=0 with mem_ready=0 → lw still completes in 5 cycles.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encoding,
// instruction field constants, datapath select codes and the control bundle.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_R_EX     = 4'd6,
        ST_R_WB     = 4'd7,
        ST_I_EX     = 4'd8,
        ST_I_WB     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_JR       = 4'd12,
        ST_TRAP     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REG    = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Every datapath enable and select driven by the controller, as one bundle
    // so reset gating can clear all of them in a single assignment.
    typedef struct packed {
        logic       pc_wr;
        logic       pc_wr_cond;
        logic       pc_wr_cond_ne;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       mem_to_reg;
        logic       ir_wr;
        logic       alu_src_a;
        logic       reg_wr;
        logic       reg_dst;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
    } ctl_t;

    // States that talk to memory and therefore wait on the ready handshake.
    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive not-ready cycles in a memory state and flags the cycle
// whose stall would be the TIMEOUT-th in a row.
module mc_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    logic [7:0] cnt_reg;

    // Clear has priority so a fresh memory state always starts from zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_reg <= '0;
        end else if (inc) begin
            cnt_reg <= cnt_reg + 8'd1;
        end
    end

    // Expire while the current stall is the last one allowed; the FSM then
    // moves to TRAP on the following edge.
    assign expire = inc && (cnt_reg == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM with memory wait states, timeout and
// illegal-instruction traps, and a retired-instruction counter.
module mc_control_unit
    import mc_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int WAIT_EN = 1,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             pc_wr,
    output logic             pc_wr_cond,
    output logic             pc_wr_cond_ne,
    output logic             iord,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             mem_to_reg,
    output logic             ir_wr,
    output logic             alu_src_a,
    output logic             reg_wr,
    output logic             reg_dst,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_op,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       state,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    state_t           state_reg, state_next;
    ctl_t             ctl_dec, ctl_out;
    logic [CNT_W-1:0] retired_reg;
    logic             ready, wait_inc, timeout, retire_evt;

    // The branch decision itself is made in the datapath from pc_wr_cond*.
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;

    assign ready    = (WAIT_EN != 0) ? mem_ready : 1'b1;
    assign wait_inc = is_mem_state(state_reg) && !ready;

    mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_next != state_reg),
        .inc    (wait_inc),
        .expire (timeout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and Moore control outputs (memory enables qualified by ready).
    always_comb begin
        state_next = state_reg;
        ctl_dec    = '0;
        case (state_reg)
            ST_FETCH: begin
                ctl_dec.mem_rd    = 1'b1;
                ctl_dec.alu_src_b = SRCB_4;
                ctl_dec.alu_op    = ALU_ADD;
                ctl_dec.pc_src    = PC_ALU;
                ctl_dec.ir_wr     = ready;
                ctl_dec.pc_wr     = ready;
                if (timeout)    state_next = ST_TRAP;
                else if (ready) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                ctl_dec.alu_src_b = SRCB_IMM_SH;
                ctl_dec.alu_op    = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW:   state_next = ST_MEM_ADDR;
                    OP_RTYPE:       state_next = (funct == FN_JR) ? ST_JR : ST_R_EX;
                    OP_ADDI:        state_next = ST_I_EX;
                    OP_BEQ, OP_BNE: state_next = ST_BRANCH;
                    OP_J:           state_next = ST_JUMP;
                    default:        state_next = ST_TRAP;
                endcase
            end
            ST_MEM_ADDR: begin
                ctl_dec.alu_src_a = 1'b1;
                ctl_dec.alu_src_b = SRCB_IMM;
                state_next = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                ctl_dec.mem_rd = 1'b1;
                ctl_dec.iord   = 1'b1;
                if (timeout)    state_next = ST_TRAP;
                else if (ready) state_next = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                ctl_dec.reg_wr     = 1'b1;
                ctl_dec.mem_to_reg = 1'b1;
                state_next = ST_FETCH;
            end
            ST_MEM_WR: begin
                ctl_dec.iord   = 1'b1;
                ctl_dec.mem_wr = 1'b1;
                if (timeout)    state_next = ST_TRAP;
                else if (ready) state_next = ST_FETCH;
            end
            ST_R_EX: begin
                ctl_dec.alu_src_a = 1'b1;
                ctl_dec.alu_op    = ALU_FUNCT;
                state_next = ST_R_WB;
            end
            ST_R_WB: begin
                ctl_dec.reg_wr  = 1'b1;
                ctl_dec.reg_dst = 1'b1;
                state_next = ST_FETCH;
            end
            ST_I_EX: begin
                ctl_dec.alu_src_a = 1'b1;
                ctl_dec.alu_src_b = SRCB_IMM;
                ctl_dec.alu_op    = ALU_ADD;
                state_next = ST_I_WB;
            end
            ST_I_WB: begin
                ctl_dec.reg_wr = 1'b1;
                state_next = ST_FETCH;
            end
            ST_BRANCH: begin
                ctl_dec.alu_src_a     = 1'b1;
                ctl_dec.alu_op        = ALU_SUB;
                ctl_dec.pc_src        = PC_ALUOUT;
                ctl_dec.pc_wr_cond    = (opcode == OP_BEQ);
                ctl_dec.pc_wr_cond_ne = (opcode == OP_BNE);
                state_next = ST_FETCH;
            end
            ST_JUMP: begin
                ctl_dec.pc_wr  = 1'b1;
                ctl_dec.pc_src = PC_JUMP;
                state_next = ST_FETCH;
            end
            ST_JR: begin
                ctl_dec.pc_wr  = 1'b1;
                ctl_dec.pc_src = PC_REG;
                state_next = ST_FETCH;
            end
            ST_TRAP: state_next = ST_TRAP;
            default: state_next = ST_TRAP;
        endcase
    end

    // No datapath writes may escape while reset is held, whatever the state.
    assign ctl_out = rst ? '0 : ctl_dec;

    // Only FETCH can loop back to FETCH (stall), so any other state heading
    // to FETCH is an instruction completing.
    assign retire_evt = (state_next == ST_FETCH) && (state_reg != ST_FETCH);

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_reg <= '0;
        end else if (retire_evt) begin
            retired_reg <= retired_reg + CNT_W'(1);
        end
    end

    assign pc_wr         = ctl_out.pc_wr;
    assign pc_wr_cond    = ctl_out.pc_wr_cond;
    assign pc_wr_cond_ne = ctl_out.pc_wr_cond_ne;
    assign iord          = ctl_out.iord;
    assign mem_rd        = ctl_out.mem_rd;
    assign mem_wr        = ctl_out.mem_wr;
    assign mem_to_reg    = ctl_out.mem_to_reg;
    assign ir_wr         = ctl_out.ir_wr;
    assign alu_src_a     = ctl_out.alu_src_a;
    assign reg_wr        = ctl_out.reg_wr;
    assign reg_dst       = ctl_out.reg_dst;
    assign pc_src        = ctl_out.pc_src;
    assign alu_op        = ctl_out.alu_op;
    assign alu_src_b     = ctl_out.alu_src_b;
    assign state         = state_reg;
    assign trap          = (state_reg == ST_TRAP);
    assign retired       = retired_reg;

endmodule
